// File: rtl/bit_serial_multiplier_sequencer.sv
// Purpose: word-level front end for the bit-serial multiplier array. It serializes two W-bit operands LSB-first with r/last_bit framing, then reassembles the serial product into a 2W-bit word.
// Latency: start accepted -> done in frame cycle 2W+LAT; ready returns one cycle later; one result per 2W+LAT+2 cycles.
// Backpressure: no queueing. start is sampled only while ready=1, and a start while busy is dropped. BSM_SIGNED_EN selects two's-complement operands.
module bit_serial_multiplier_sequencer #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   x_word,
    input  logic [W-1:0]   y_word,
    output logic           ready,
    output logic           x,
    output logic           y,
    output logic           xy,
    output logic           r,
    output logic           last_bit,
    input  logic           p_in,
    output logic [2*W-1:0] p_word,
    output logic           done
);

    localparam int CW = $clog2(2 * W + LAT + 1);

    localparam logic [CW-1:0] PRE_LAST    = CW'(2 * W - 2);
    localparam logic [CW-1:0] LAST_STREAM = CW'(2 * W - 1);
    localparam logic [CW-1:0] LAST_DRAIN  = CW'(2 * W - 1 + LAT);
    localparam logic [CW-1:0] LAT_C       = CW'(LAT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

`ifdef BSM_SIGNED_EN
    localparam logic SIGNED_OPS = 1'b1;
`else
    localparam logic SIGNED_OPS = 1'b0;
`endif

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   x_sr;
    logic [W-1:0]   y_sr;
    logic [2*W-1:0] p_sr;

    logic accept;
    logic cap_en;
    logic enter_done;
    logic x_fill;
    logic y_fill;
    logic xw_fill;
    logic yw_fill;

    // Bit 0 goes straight to the output registers on accept. The shift registers
    // hold bits 1..W-1. Once they are consumed, the vacated MSB refills with the
    // extension bit (the sign bit when signed, otherwise 0).
    assign accept     = (state == S_IDLE) && start;
    assign x_fill     = SIGNED_OPS & x_sr[W-1];
    assign y_fill     = SIGNED_OPS & y_sr[W-1];
    assign xw_fill    = SIGNED_OPS & x_word[W-1];
    assign yw_fill    = SIGNED_OPS & y_word[W-1];

    // Product bit i arrives LAT cycles after operand bit i. The capture window
    // is therefore offset by LAT and spans STREAM plus DRAIN.
    assign cap_en     = ((state == S_STREAM) || (state == S_DRAIN)) && (cnt >= LAT_C);
    assign enter_done = ((state == S_STREAM) && (cnt == LAST_STREAM) && (LAT == 0)) ||
                        ((state == S_DRAIN)  && (cnt == LAST_DRAIN));

    // Frame sequencing: the counter equals the frame cycle number; ready and done are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= enter_done;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_STREAM;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                S_STREAM: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STREAM) begin
                        state <= (LAT == 0) ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_DRAIN) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Serializer: drive bit k in cycle k and frame markers r (cycle 0) and last_bit (cycle 2W-1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= 1'b0;
            y        <= 1'b0;
            xy       <= 1'b0;
            r        <= 1'b0;
            last_bit <= 1'b0;
            x_sr     <= '0;
            y_sr     <= '0;
        end else if (accept) begin
            x        <= x_word[0];
            y        <= y_word[0];
            xy       <= x_word[0] & y_word[0];
            r        <= 1'b1;
            last_bit <= 1'b0;
            x_sr     <= {xw_fill, x_word[W-1:1]};
            y_sr     <= {yw_fill, y_word[W-1:1]};
        end else if ((state == S_STREAM) && (cnt != LAST_STREAM)) begin
            x        <= x_sr[0];
            y        <= y_sr[0];
            xy       <= x_sr[0] & y_sr[0];
            r        <= 1'b0;
            last_bit <= (cnt == PRE_LAST);
            x_sr     <= {x_fill, x_sr[W-1:1]};
            y_sr     <= {y_fill, y_sr[W-1:1]};
        end else begin
            x        <= 1'b0;
            y        <= 1'b0;
            xy       <= 1'b0;
            r        <= 1'b0;
            last_bit <= 1'b0;
        end
    end

    // Deserializer: shift product bits in from the MSB. The final capture and the
    // p_word load share one edge, so p_word takes the shifted value directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_sr   <= '0;
            p_word <= '0;
        end else begin
            if (accept) begin
                p_sr <= '0;
            end else if (cap_en) begin
                p_sr <= {p_in, p_sr[2*W-1:1]};
            end
            if (enter_done) begin
                p_word <= {p_in, p_sr[2*W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_multiplier_sequencer.sv
// Purpose: self-checking bench for bit_serial_multiplier_sequencer with two instances (W=8/LAT=1 and W=4/LAT=3).
// Latency: each instance's p_in is driven by a behavioural array model that returns product bit i in cycle i+LAT.
// Backpressure: the bench waits for ready with a bounded budget and also exercises the busy-start and mid-frame reset cases.
module tb_bit_serial_multiplier_sequencer;

    localparam int W8 = 8;
    localparam int L8 = 1;
    localparam int W4 = 4;
    localparam int L4 = 3;

`ifdef BSM_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start_c;
    logic       sel;
    logic [7:0] xw;
    logic [7:0] yw;

    logic       start8, rdy8, x8, y8, xy8, r8, lb8, done8, pin8;
    logic [15:0] pw8;
    logic       start4, rdy4, x4, y4, xy4, r4, lb4, done4, pin4;
    logic [7:0] pw4;

    assign start8 = start_c & ~sel;
    assign start4 = start_c & sel;

    bit_serial_multiplier_sequencer #(.W(W8), .LAT(L8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .x_word(xw), .y_word(yw),
        .ready(rdy8), .x(x8), .y(y8), .xy(xy8), .r(r8), .last_bit(lb8),
        .p_in(pin8), .p_word(pw8), .done(done8)
    );

    bit_serial_multiplier_sequencer #(.W(W4), .LAT(L4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .x_word(xw[3:0]), .y_word(yw[3:0]),
        .ready(rdy4), .x(x4), .y(y4), .xy(xy4), .r(r4), .last_bit(lb4),
        .p_in(pin4), .p_word(pw4), .done(done4)
    );

    // Mux of the currently selected instance so one task can drive either.
    logic c_rdy, c_x, c_y, c_xy, c_r, c_lb, c_done;
    logic [15:0] c_pw;
    assign c_rdy  = sel ? rdy4  : rdy8;
    assign c_x    = sel ? x4    : x8;
    assign c_y    = sel ? y4    : y8;
    assign c_xy   = sel ? xy4   : xy8;
    assign c_r    = sel ? r4    : r8;
    assign c_lb   = sel ? lb4   : lb8;
    assign c_done = sel ? done4 : done8;
    assign c_pw   = sel ? {8'h00, pw4} : pw8;

    // Array model, W=8: record the incoming bit pair and multiply what has arrived.
    // Product bit k then goes back on p_in LAT cycles later; outside the window p_in is random.
    int          idx8;
    logic        act8;
    logic [15:0] xb8, yb8, pb8;
    always @(negedge clk or negedge reset_n) begin : model8
        int k;
        logic a;
        logic [15:0] xs, ys, pv;
        logic [31:0] pr;
        if (!reset_n) begin
            idx8 <= 0; act8 <= 1'b0; xb8 <= '0; yb8 <= '0; pb8 <= '0; pin8 <= 1'b0;
        end else begin
            a  = act8 | r8;
            k  = r8 ? 0 : idx8 + 1;
            xs = r8 ? 16'h0 : xb8;
            ys = r8 ? 16'h0 : yb8;
            pv = r8 ? 16'h0 : pb8;
            if (a && k < 2 * W8) begin
                xs[k] = x8;
                ys[k] = y8;
                pr    = 32'(xs) * 32'(ys);
                pv[k] = pr[k];
            end
            if (a && k >= L8 && k - L8 < 2 * W8) pin8 <= pv[k - L8];
            else                                 pin8 <= 1'($urandom);
            idx8 <= (k > 1000) ? 1000 : k;
            act8 <= a;
            xb8 <= xs; yb8 <= ys; pb8 <= pv;
        end
    end

    // Array model, W=4: the same behaviour at the smaller width and longer latency.
    int          idx4;
    logic        act4;
    logic [7:0]  xb4, yb4, pb4;
    always @(negedge clk or negedge reset_n) begin : model4
        int k;
        logic a;
        logic [7:0] xs, ys, pv;
        logic [15:0] pr;
        if (!reset_n) begin
            idx4 <= 0; act4 <= 1'b0; xb4 <= '0; yb4 <= '0; pb4 <= '0; pin4 <= 1'b0;
        end else begin
            a  = act4 | r4;
            k  = r4 ? 0 : idx4 + 1;
            xs = r4 ? 8'h0 : xb4;
            ys = r4 ? 8'h0 : yb4;
            pv = r4 ? 8'h0 : pb4;
            if (a && k < 2 * W4) begin
                xs[k] = x4;
                ys[k] = y4;
                pr    = 16'(xs) * 16'(ys);
                pv[k] = pr[k];
            end
            if (a && k >= L4 && k - L4 < 2 * W4) pin4 <= pv[k - L4];
            else                                 pin4 <= 1'($urandom);
            idx4 <= (k > 1000) ? 1000 : k;
            act4 <= a;
            xb4 <= xs; yb4 <= ys; pb4 <= pv;
        end
    end

    int tests;
    int fails;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Operand extended to 2W bits: sign extension when signed, zero extension otherwise.
    function automatic logic [63:0] ext(input logic [31:0] v, input int w);
        logic [63:0] e;
        e = 64'(v) & ((64'd1 << w) - 64'd1);
        if (SGN && e[w-1]) e = e | (((64'd1 << (2 * w)) - 64'd1) & ~((64'd1 << w) - 64'd1));
        return e;
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input int w);
        return (ext(a, w) * ext(b, w)) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One full multiply on the selected instance, starting at #1 after an edge.
    // The task returns in the cycle where ready comes back, so back-to-back calls start at once.
    task automatic do_mul(input logic [7:0] xv, input logic [7:0] yv, input logic [63:0] want,
                          input string nm);
        int w, lat, n, to;
        logic [63:0] rm, lm, dm, qm, xm, ym, xym, pv;
        w   = sel ? W4 : W8;
        lat = sel ? L4 : L8;
        n   = 2 * w + lat + 1;
        to  = 0;
        while (!c_rdy && to < 100) begin
            @(posedge clk); #1;
            to++;
        end
        chk({nm, "/ready_pre"}, 64'(c_rdy), 64'd1);
        xw = xv; yw = yv; start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        xw = 8'($urandom); yw = 8'($urandom);
        rm = '0; lm = '0; dm = '0; qm = '0; xm = '0; ym = '0; xym = '0;
        pv = 64'hDEAD;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            rm[k] = c_r;
            lm[k] = c_lb;
            dm[k] = c_done;
            qm[k] = c_rdy;
            if (c_done) pv = 64'(c_pw);
            if (k < 2 * w) begin
                xm[k] = c_x; ym[k] = c_y; xym[k] = c_xy;
            end
        end
        chk({nm, "/r"},        rm, 64'd1);
        chk({nm, "/last_bit"}, lm, 64'd1 << (2 * w - 1));
        chk({nm, "/done"},     dm, 64'd1 << (2 * w + lat));
        chk({nm, "/ready"},    qm, 64'd1 << n);
        chk({nm, "/x"},        xm, ext(32'(xv), w));
        chk({nm, "/y"},        ym, ext(32'(yv), w));
        chk({nm, "/xy"},       xym, ext(32'(xv), w) & ext(32'(yv), w));
        chk({nm, "/p_word"},   pv, want);
        chk({nm, "/p_hold"},   64'(c_pw), want);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] pu;
        logic [15:0] ps;
    } vec_t;

    vec_t tbl[7];

    initial begin : main
        int dc, rc;
        logic [7:0] ra, rb;
        logic [15:0] pv;
        tests = 0; fails = 0;
        reset_n = 1'b0; start_c = 1'b0; sel = 1'b0; xw = '0; yw = '0;

        tbl[0] = '{8'd13,  8'd11,  16'h008F, 16'h008F};
        tbl[1] = '{8'hFF,  8'hFF,  16'hFE01, 16'h0001};
        tbl[2] = '{8'hFD,  8'h05,  16'h04F1, 16'hFFF1};
        tbl[3] = '{8'h00,  8'h00,  16'h0000, 16'h0000};
        tbl[4] = '{8'h80,  8'h80,  16'h4000, 16'h4000};
        tbl[5] = '{8'h7F,  8'h80,  16'h3F80, 16'hC080};
        tbl[6] = '{8'h01,  8'hFF,  16'h00FF, 16'hFFFF};

        #12;
        chk("reset8/ctl", 64'({rdy8, x8, y8, xy8, r8, lb8, done8}), 64'b1000000);
        chk("reset8/p_word", 64'(pw8), 64'd0);
        chk("reset4/ctl", 64'({rdy4, x4, y4, xy4, r4, lb4, done4}), 64'b1000000);
        chk("reset4/p_word", 64'(pw4), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        sel = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_mul(tbl[i].a, tbl[i].b, 64'(SGN ? tbl[i].ps : tbl[i].pu), $sformatf("tbl%0d", i));
        end
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            do_mul(ra, rb, ref_mul(32'(ra), 32'(rb), W8), $sformatf("rnd8_%0d", i));
        end

        // Busy start: a 7*7 request in cycle 5 of a 2*3 frame must be dropped.
        xw = 8'd2; yw = 8'd3; start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        dc = 0; rc = 0; pv = '0;
        for (int k = 0; k < 40; k++) begin
            if (c_done) begin dc++; pv = c_pw; end
            if (c_r) rc++;
            if (k == 5) begin xw = 8'd7; yw = 8'd7; end
            start_c = (k == 5);
            @(posedge clk); #1;
        end
        start_c = 1'b0;
        chk("busy/done_count", 64'(dc), 64'd1);
        chk("busy/r_count", 64'(rc), 64'd1);
        chk("busy/p_word", 64'(pv), 64'h0006);
        chk("busy/ready", 64'(c_rdy), 64'd1);

        // Reset mid-frame: abort in cycle 9; no done afterwards; then a clean 4*4.
        xw = 8'd5; yw = 8'd6; start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        chk("midrst/ctl", 64'({c_rdy, c_x, c_y, c_xy, c_r, c_lb, c_done}), 64'b1000000);
        chk("midrst/p_word", 64'(c_pw), 64'd0);
        #2;
        reset_n = 1'b1;
        dc = 0; rc = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (c_done) dc++;
            if (c_r) rc++;
        end
        chk("midrst/no_done", 64'(dc), 64'd0);
        chk("midrst/no_frame", 64'(rc), 64'd0);
        do_mul(8'd4, 8'd4, 64'h0010, "after_rst");

        // W=4, LAT=3: back-to-back frames, then random operands.
        sel = 1'b1;
        @(posedge clk); #1;
        do_mul(8'd15, 8'd6 + 8'd9, SGN ? 64'h01 : 64'hE1, "w4_15x15");
        do_mul(8'd9,  8'd6,        SGN ? 64'hD6 : 64'h36, "w4_9x6");
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15));
            do_mul(ra, rb, ref_mul(32'(ra), 32'(rb), W4), $sformatf("rnd4_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serial_multiplier_sequencer.md
# bit_serial_multiplier_sequencer

Word-level front end for the bit-serial multiplier array. It accepts two parallel W-bit operands and streams them LSB-first into slice 0 as x/y/xy bits. It generates the position token `r` and the `last_bit` frame marker, then collects the serial product stream and reassembles it into a parallel 2W-bit word. It is the serializer/deserializer counterpart to the multiplier slices, sitting between the word-level datapath and the slice chain.

## Interface
- `W`, 8: operand width in bits; legal range 2..32.
- `LAT`, 1: cycles from driving bit i on `x`/`y` to product bit i appearing on `p_in`; legal range 0..7.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only while `ready`=1.
- `x_word`  in  W  multiplicand; captured when `start` is accepted.
- `y_word`  in  W  multiplier; captured when `start` is accepted.
- `ready`  out  1  idle; a new `start` will be accepted.
- `x`  out  1  serial multiplicand bit to slice 0.
- `y`  out  1  serial multiplier bit to slice 0.
- `xy`  out  1  `x & y` of the current bit pair.
- `r`  out  1  position token; high only in frame cycle 0.
- `last_bit`  out  1  high in frame cycle 2W-1; clears slice feedback state.
- `p_in`  in  1  serial product bit from the array tail.
- `p_word`  out  2W  assembled product; holds its value until the next `done`.
- `done`  out  1  one-cycle pulse; `p_word` is valid in this cycle.

## Operation
- FSM states:
  - IDLE: `ready`=1.
  - STREAM: 2W cycles.
  - DRAIN: LAT cycles, skipped if LAT=0.
  - DONE: 1 cycle.
- IDLE -> STREAM when `start`=1 at a clock edge. Capture `x_word` and `y_word` into shift registers and clear the cycle counter.
- STREAM, frame cycle k = 0..2W-1:
  - For k<W, `x` = x_word[k] and `y` = y_word[k].
  - For k>=W, `x` and `y` are the extension bits (see Configuration).
  - `xy` = `x & y`.
  - `r` = 1 only when k=0.
  - `last_bit` = 1 only when k=2W-1.
- Capture: at the edge ending frame cycle c, when LAT <= c <= 2W-1+LAT, shift `p_in` into the MSB of the product shift register (right shift). After 2W captures, bit i sits at position i.
- STREAM -> DRAIN (or -> DONE if LAT=0) after cycle 2W-1. DRAIN -> DONE after LAT cycles. DONE -> IDLE unconditionally.
- `p_word` loads from the shift register on entry to DONE. `done`=1 for exactly that cycle.
- `start` while `ready`=0 is ignored; it is not queued.
- Arithmetic: unsigned by default. The product is modulo 2^(2W) and never overflows for unsigned operands.
- Cycle counter width: clog2(2W+LAT+1) bits. No wrap occurs within a frame.
- All outputs are registered.

## Timing
- Reset values: `ready`=1; `x`, `y`, `xy`, `r`, `last_bit`, `done` = 0; `p_word`=0; FSM in IDLE; all shift registers and the counter cleared.
- `reset_n` asserted mid-frame: immediate abort to the reset values above. No `done` pulse is produced and the partial product is discarded.
- Cycle numbering: the accepting edge ends cycle -1. Bit k is driven during cycle k.
- `done` is high in cycle 2W+LAT. `ready` returns in cycle 2W+LAT+1, so `start` can be accepted at the edge ending that cycle.
- Back-to-back throughput: one result per 2W+LAT+2 cycles.
- With W=8, LAT=1: `done` in cycle 17, `ready` in cycle 18.

## Configuration
- `BSM_SIGNED_EN` defined:
  - Operands are two's complement.
  - For k>=W, `x` = x_word[W-1] and `y` = y_word[W-1] (sign extension).
  - `p_word` is the two's-complement 2W-bit product.
- `BSM_SIGNED_EN` undefined:
  - Extension bits are 0.
  - Operands and product are unsigned.
- Either way, the port list and timing are identical.

## Test plan
- The bench uses a behavioural array model: it computes the 2W-bit product of the extended streams and returns bit i on `p_in` in cycle i+LAT.
- W=8, LAT=1, unsigned: start with x_word=13, y_word=11 -> `r` high in cycle 0 only, `last_bit` high in cycle 15 only, `done` in cycle 17, `p_word`=0x008F.
- W=8, LAT=1, unsigned: 255*255 -> `p_word`=0xFE01. During cycles 8..15, `x`=`y`=`xy`=0.
- W=8, LAT=1, `BSM_SIGNED_EN` defined: x_word=0xFD (-3), y_word=0x05 -> during cycles 8..15, `x`=1 and `y`=0. `p_word`=0xFFF1 (-15).
- Busy start: pulse `start` with 7*7 in cycle 5 of a 2*3 frame -> single `done` with `p_word`=0x0006. Then `ready`=1 and no second frame begins.
- Reset mid-frame: deassert `reset_n` in cycle 9 -> all outputs return to reset values asynchronously and no `done` follows. A subsequent 4*4 request returns 0x0010.
- W=4, LAT=3: back-to-back 15*15 then 9*6, each started the cycle `ready` rises -> `done` in cycle 11 of each frame, giving `p_word`=0xE1 then 0x36.
